line_pair_ctrl: RTL and testbench

- Upstream controller for pingpong_ram in the algorithm path.
- Converts the raw video pixel stream (vs/de/pixel) into line-buffer write/read strobes and a bank-toggle pulse.
- Re-aligns each incoming pixel with the co-located pixel of the previous line returned by the buffer.
- Emits aligned (current, above) pairs to the downstream vertical filter stages.

---
 rtl/line_pair_ctrl.sv | 170 +++++++++++++++++
 tb/tb_line_pair_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_pair_ctrl.sv
// Line-buffer controller: turns vs/de/pixel into ping-pong RAM strobes and emits (current, above)
// pixel pairs. Define LINE_PAIR_EDGE_REPLICATE_EN to replicate the top line into up_pix.
module line_pair_ctrl #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 11,
   parameter int unsigned LINE_LEN   = 1280
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  vs_in,
   input  logic                  de_in,
   input  logic [DATA_WIDTH-1:0] pix_in,
   output logic                  ram_we,
   output logic                  ram_re,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   output logic                  ram_swap,
   input  logic [DATA_WIDTH-1:0] ram_rdata,
   output logic                  de_out,
   output logic [DATA_WIDTH-1:0] cur_pix,
   output logic [DATA_WIDTH-1:0] up_pix,
   output logic                  up_valid,
   output logic [ADDR_WIDTH-1:0] line_cnt,
   output logic                  len_err
);

   typedef enum logic [1:0] {StIdle, StSync, StFirst, StStream} state_e;

   localparam int unsigned ColW = ADDR_WIDTH + 1;
   localparam logic [ColW-1:0]       LineLen = ColW'(LINE_LEN);
   localparam logic [ColW-1:0]       ColMax  = '1;
   localparam logic [ADDR_WIDTH-1:0] CntMax  = '1;

   state_e                  state_q, state_d;
   logic                    vs_q, de_q;
   logic [ColW-1:0]         col_q, col_d;
   logic [ADDR_WIDTH-1:0]   line_cnt_q, line_cnt_d;
   logic                    len_err_q, len_err_d;
   logic                    we_q, we_d, re_q, re_d, swap_q, swap_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic                    first1_q, first1_d;
   logic                    v2_q, first2_q;
   logic [DATA_WIDTH-1:0]   cur2_q;
   logic                    de_out_q, de_out_d, up_valid_q, up_valid_d;
   logic [DATA_WIDTH-1:0]   cur_pix_q, cur_pix_d, up_pix_q, up_pix_d;

   logic vs_rise, de_fall, in_range, accept, overflow, line_end;

   always_comb begin
      vs_rise    = vs_in & ~vs_q;
      de_fall    = de_q & ~de_in;
      in_range   = (col_q < LineLen);
      accept     = 1'b0;
      overflow   = 1'b0;
      line_end   = 1'b0;
      state_d    = state_q;
      col_d      = col_q;
      line_cnt_d = line_cnt_q;
      len_err_d  = len_err_q;

      // A frame start aborts whatever line is in flight.
      if (vs_rise) begin
         state_d    = StSync;
         col_d      = '0;
         line_cnt_d = '0;
         len_err_d  = 1'b0;
      end else begin
         unique case (state_q)
            StIdle: ;
            StSync: if (!de_in) state_d = StFirst;
            StFirst, StStream: begin
               if (de_in) begin
                  accept   = in_range;
                  overflow = ~in_range;
                  if (col_q != ColMax) col_d = col_q + 1'b1;
               end else if (de_fall) begin
                  line_end = 1'b1;
                  col_d    = '0;
                  state_d  = StStream;
               end
            end
            default: state_d = StIdle;
         endcase
         if (overflow || (line_end && in_range)) len_err_d = 1'b1;
         if (line_end && (line_cnt_q != CntMax)) line_cnt_d = line_cnt_q + 1'b1;
      end

      we_d     = accept;
      re_d     = accept & (state_q == StStream);
      wdata_d  = accept ? pix_in : wdata_q;
      first1_d = (state_q == StFirst);
      swap_d   = line_end;
   end

   // Output stage: pair the delayed pixel with the buffer's read data.
   always_comb begin
      de_out_d   = v2_q;
      cur_pix_d  = cur_pix_q;
      up_pix_d   = up_pix_q;
      up_valid_d = up_valid_q;
      if (v2_q) begin
         cur_pix_d = cur2_q;
         if (first2_q) begin
`ifdef LINE_PAIR_EDGE_REPLICATE_EN
            up_pix_d   = cur2_q;
            up_valid_d = 1'b1;
`else
            up_pix_d   = '0;
            up_valid_d = 1'b0;
`endif
         end else begin
            up_pix_d   = ram_rdata;
            up_valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= StIdle;
         vs_q       <= 1'b0;
         de_q       <= 1'b0;
         col_q      <= '0;
         line_cnt_q <= '0;
         len_err_q  <= 1'b0;
         we_q       <= 1'b0;
         re_q       <= 1'b0;
         swap_q     <= 1'b0;
         wdata_q    <= '0;
         first1_q   <= 1'b0;
         v2_q       <= 1'b0;
         first2_q   <= 1'b0;
         cur2_q     <= '0;
         de_out_q   <= 1'b0;
         cur_pix_q  <= '0;
         up_pix_q   <= '0;
         up_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         vs_q       <= vs_in;
         de_q       <= de_in;
         col_q      <= col_d;
         line_cnt_q <= line_cnt_d;
         len_err_q  <= len_err_d;
         we_q       <= we_d;
         re_q       <= re_d;
         swap_q     <= swap_d;
         wdata_q    <= wdata_d;
         first1_q   <= first1_d;
         v2_q       <= we_q;
         first2_q   <= first1_q;
         cur2_q     <= wdata_q;
         de_out_q   <= de_out_d;
         cur_pix_q  <= cur_pix_d;
         up_pix_q   <= up_pix_d;
         up_valid_q <= up_valid_d;
      end
   end

   assign ram_we    = we_q;
   assign ram_re    = re_q;
   assign ram_wdata = wdata_q;
   assign ram_swap  = swap_q;
   assign de_out    = de_out_q;
   assign cur_pix   = cur_pix_q;
   assign up_pix    = up_pix_q;
   assign up_valid  = up_valid_q;
   assign line_cnt  = line_cnt_q;
   assign len_err   = len_err_q;

endmodule

// File: tb/tb_line_pair_ctrl.sv
// Bench for line_pair_ctrl: ping-pong RAM model, line-level reference model with per-cycle
// expectations, directed scenarios plus randomized lines.
module tb_line_pair_ctrl;
   localparam int DW = 8, AW = 4, LEN = 8, NCYC = 4096;

   logic clk = 1'b0, reset = 1'b0, vs_in = 1'b0, de_in = 1'b0;
   logic [DW-1:0] pix_in = '0;
   logic ram_we, ram_re, ram_swap, de_out, up_valid, len_err;
   logic [DW-1:0] ram_wdata, cur_pix, up_pix;
   logic [DW-1:0] ram_rdata;
   logic [AW-1:0] line_cnt;

   line_pair_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LINE_LEN(LEN)) dut (
      .clk(clk), .reset(reset), .vs_in(vs_in), .de_in(de_in), .pix_in(pix_in),
      .ram_we(ram_we), .ram_re(ram_re), .ram_wdata(ram_wdata), .ram_swap(ram_swap),
      .ram_rdata(ram_rdata), .de_out(de_out), .cur_pix(cur_pix), .up_pix(up_pix),
      .up_valid(up_valid), .line_cnt(line_cnt), .len_err(len_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0, n_pass = 0, cyc = 0;
   bit chk_en = 1'b0, rst_drv = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
   endtask

   // Ping-pong buffer: one bank written, the other read; pointers restart on swap or frame start.
   logic [DW-1:0] mem [2][16];
   bit bank = 1'b0;
   logic [3:0] wp, rp;
   logic vs_prev;
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         wp <= '0; rp <= '0; ram_rdata <= '0; vs_prev <= 1'b0;
      end else begin
         if (ram_re) begin ram_rdata <= mem[!bank][rp]; rp <= rp + 1'b1; end
         if (ram_we) begin mem[bank][wp] <= ram_wdata; wp <= wp + 1'b1; end
         if (ram_swap) begin bank <= !bank; wp <= '0; rp <= '0; end
         if (vs_in && !vs_prev) begin wp <= '0; rp <= '0; end
         vs_prev <= vs_in;
      end
   end

   // Expected outputs per cycle.
   bit exp_we[NCYC], exp_re[NCYC], exp_swap[NCYC], exp_de[NCYC], exp_uv[NCYC], exp_upk[NCYC];
   bit exp_err[NCYC];
   bit [DW-1:0] exp_wd[NCYC], exp_cur[NCYC], exp_up[NCYC];
   int exp_cnt[NCYC];

   // Reference model state, in frame/line terms.
   bit m_in_frame, m_need_gap, m_first, m_err, m_vsp, m_dep;
   int m_col, m_lines, m_prev_len;
   bit [DW-1:0] m_cur[LEN], m_prev[LEN];

   task automatic model_clear();
      m_in_frame = 0; m_need_gap = 0; m_first = 0; m_err = 0; m_vsp = 0; m_dep = 0;
      m_col = 0; m_lines = 0; m_prev_len = 0;
      for (int i = cyc + 1; i < NCYC; i++) begin
         exp_we[i] = 0; exp_re[i] = 0; exp_swap[i] = 0; exp_de[i] = 0;
         exp_cnt[i] = 0; exp_err[i] = 0;
      end
   endtask

   task automatic model_step();
      int n = cyc;
      bit vr, fall;
      if (!reset) begin model_clear(); return; end
      vr = vs_in && !m_vsp;
      fall = !de_in && m_dep;
      if (vr) begin
         m_in_frame = 1; m_need_gap = 1; m_col = 0; m_lines = 0; m_err = 0;
      end else if (m_in_frame) begin
         if (m_need_gap) begin
            if (!de_in) begin m_need_gap = 0; m_first = 1; m_col = 0; end
         end else if (de_in) begin
            if (m_col < LEN) begin
               exp_we[n+1] = 1; exp_wd[n+1] = pix_in; exp_re[n+1] = !m_first;
               exp_de[n+3] = 1; exp_cur[n+3] = pix_in;
               if (m_first) begin
`ifdef LINE_PAIR_EDGE_REPLICATE_EN
                  exp_up[n+3] = pix_in; exp_uv[n+3] = 1;
`else
                  exp_up[n+3] = '0; exp_uv[n+3] = 0;
`endif
                  exp_upk[n+3] = 1;
               end else begin
                  exp_up[n+3] = m_prev[m_col]; exp_uv[n+3] = 1;
                  exp_upk[n+3] = (m_col < m_prev_len);
               end
               m_cur[m_col] = pix_in;
            end else m_err = 1;
            m_col++;
         end else if (fall) begin
            if (m_col < LEN) m_err = 1;
            if (m_lines < (1 << AW) - 1) m_lines++;
            exp_swap[n+1] = 1;
            m_prev = m_cur;
            m_prev_len = (m_col < LEN) ? m_col : LEN;
            m_first = 0; m_col = 0;
         end
      end
      m_vsp = vs_in; m_dep = de_in;
      exp_cnt[n+1] = m_lines; exp_err[n+1] = m_err;
   endtask

   // Observation counters and captured output pairs.
   int we_cnt = 0, de_cnt = 0, swap_cnt = 0;
   int cap_cyc[$];
   bit [DW-1:0] cap_cur[$], cap_up[$];
   bit cap_uv[$];

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (ram_we === 1'b1) we_cnt++;
      if (ram_swap === 1'b1) swap_cnt++;
      if (de_out === 1'b1) begin
         de_cnt++;
         cap_cyc.push_back(cyc); cap_cur.push_back(cur_pix);
         cap_up.push_back(up_pix); cap_uv.push_back(up_valid);
      end
      if (chk_en) begin
         chk("ram_we", ram_we, exp_we[cyc]);
         if (exp_we[cyc]) chk("ram_wdata", ram_wdata, exp_wd[cyc]);
         chk("ram_re", ram_re, exp_re[cyc]);
         chk("ram_swap", ram_swap, exp_swap[cyc]);
         chk("de_out", de_out, exp_de[cyc]);
         if (exp_de[cyc]) begin
            chk("cur_pix", cur_pix, exp_cur[cyc]);
            chk("up_valid", up_valid, exp_uv[cyc]);
            if (exp_upk[cyc]) chk("up_pix", up_pix, exp_up[cyc]);
         end
         chk("line_cnt", line_cnt, exp_cnt[cyc]);
         chk("len_err", len_err, exp_err[cyc]);
      end
   end

   task automatic step(input logic v, input logic d, input logic [DW-1:0] p);
      @(posedge clk);
      #1;
      if (cyc + 5 >= NCYC) begin
         $display("FAIL cycle_budget: got %0d cycles, limit %0d", cyc, NCYC - 5);
         $fatal(1);
      end
      reset = rst_drv; vs_in = v; de_in = d; pix_in = p;
      model_step();
   endtask

   task automatic idle(input int k);
      repeat (k) step(1'b0, 1'b0, '0);
   endtask

   task automatic vs_pulse();
      step(1'b1, 1'b0, '0); step(1'b1, 1'b0, '0); step(1'b0, 1'b0, '0);
   endtask

   task automatic line(input int len, input int base);
      for (int i = 0; i < len; i++) step(1'b0, 1'b1, DW'(base + i));
      step(1'b0, 1'b0, '0);
   endtask

   task automatic clear_obs();
      we_cnt = 0; de_cnt = 0; swap_cnt = 0;
      cap_cyc.delete(); cap_cur.delete(); cap_up.delete(); cap_uv.delete();
   endtask

   int t_line2;

   initial begin
      model_clear();
      idle(3);
      #3;
      chk("rst_ram_we", ram_we, 0); chk("rst_de_out", de_out, 0);
      chk("rst_line_cnt", line_cnt, 0); chk("rst_len_err", len_err, 0);
      rst_drv = 1'b1;
      step(1'b0, 1'b0, '0);
      chk_en = 1'b1;
      idle(2);

      // Two full lines: second line pairs with the first.
      clear_obs();
      vs_pulse(); idle(1);
      line(LEN, 0); idle(2);
      t_line2 = cyc + 1;
      line(LEN, 10); idle(4);
      chk("pair_count", cap_cur.size(), 16);
      if (cap_cur.size() == 16) begin
         chk("line2_latency", cap_cyc[8] - t_line2, 3);
         for (int i = 0; i < 8; i++) begin
            chk("l1_cur", cap_cur[i], i);
`ifdef LINE_PAIR_EDGE_REPLICATE_EN
            chk("l1_up", cap_up[i], i); chk("l1_uv", cap_uv[i], 1);
`else
            chk("l1_up", cap_up[i], 0); chk("l1_uv", cap_uv[i], 0);
`endif
            chk("l2_cur", cap_cur[8+i], 10 + i);
            chk("l2_up", cap_up[8+i], i);
            chk("l2_uv", cap_uv[8+i], 1);
         end
      end
      chk("t1_line_cnt", line_cnt, 2); chk("t1_len_err", len_err, 0);

      // Long line: only LEN pixels written.
      clear_obs();
      line(10, 8'h40); idle(4);
      chk("long_we_cnt", we_cnt, 8); chk("long_de_cnt", de_cnt, 8);
      chk("long_len_err", len_err, 1);
      idle(2);
      chk("long_err_sticky", len_err, 1);

      // Short line in a fresh frame.
      vs_pulse(); idle(1);
      chk("vs_clr_err", len_err, 0); chk("vs_clr_cnt", line_cnt, 0);
      clear_obs();
      line(5, 8'h80); idle(4);
      chk("short_err", len_err, 1); chk("short_swap", swap_cnt, 1);
      chk("short_cnt", line_cnt, 1);

      // Frame start in the middle of a line.
      vs_pulse(); idle(1);
      line(LEN, 1); idle(2);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, DW'(8'h50 + i));
      step(1'b1, 1'b1, 8'h53);
      step(1'b1, 1'b1, 8'h54);
      #3;
      chk("abort_we", ram_we, 0); chk("abort_re", ram_re, 0);
      chk("abort_cnt", line_cnt, 0); chk("abort_err", len_err, 0);
      step(1'b0, 1'b1, 8'h55); step(1'b0, 1'b0, '0); idle(3);
      clear_obs();
      line(LEN, 8'h60); idle(4);
      chk("abort_next_pairs", cap_uv.size(), 8);
`ifndef LINE_PAIR_EDGE_REPLICATE_EN
      if (cap_uv.size() == 8) chk("abort_next_uv", cap_uv[0], 0);
`endif

      // Randomized lines, occasional aborts; line_cnt saturates.
      vs_pulse(); idle(1);
      repeat (40) begin
         int len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(4, 11)) : LEN;
         if ($urandom_range(0, 11) == 0) begin
            for (int i = 0; i < len / 2; i++) step(1'b0, 1'b1, DW'($urandom));
            step(1'b1, 1'b1, DW'($urandom)); step(1'b1, 1'b0, '0); step(1'b0, 1'b0, '0);
         end else begin
            for (int i = 0; i < len; i++) step(1'b0, 1'b1, DW'($urandom));
            step(1'b0, 1'b0, '0);
         end
         idle($urandom_range(1, 4));
      end
      idle(4);

      // Asynchronous reset mid-line.
      vs_pulse(); idle(1);
      line(LEN, 2); idle(2);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, DW'(8'h70 + i));
      chk_en = 1'b0;
      #2;
      rst_drv = 1'b0; reset = 1'b0;
      model_clear();
      #1;
      chk("arst_we", ram_we, 0); chk("arst_re", ram_re, 0); chk("arst_swap", ram_swap, 0);
      chk("arst_wdata", ram_wdata, 0); chk("arst_de", de_out, 0);
      chk("arst_cur", cur_pix, 0); chk("arst_up", up_pix, 0); chk("arst_uv", up_valid, 0);
      chk("arst_cnt", line_cnt, 0); chk("arst_err", len_err, 0);
      step(1'b0, 1'b1, 8'h74); step(1'b0, 1'b1, 8'h75);
      rst_drv = 1'b1;
      step(1'b0, 1'b1, 8'h76);
      chk_en = 1'b1;
      clear_obs();
      step(1'b0, 1'b0, '0); idle(1);
      line(LEN, 3); idle(4);
      chk("post_rst_no_we", we_cnt, 0);
      vs_pulse(); idle(1);
      clear_obs();
      line(LEN, 4); idle(4);
      chk("post_vs_we", we_cnt, 8);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
